// File: rtl/clock_set_controller_if.sv
// Signal bundle between the clock set controller and its surroundings:
// timebase and buttons in, counter values in, counter strobes and mode out.
// The controller connects through the slave modport; whatever drives the
// buttons, tick and counter values uses the master modport.
interface clock_set_controller_if;
    logic       i_tick;
    logic       i_btn_mode;
    logic       i_btn_up;
    logic       i_btn_down;
    logic [7:0] i_sec_q;
    logic [7:0] i_min_q;
    logic [7:0] i_hr_q;

    logic       o_sec_ena;
    logic       o_min_ena;
    logic       o_hr_ena;
    logic       o_up;
    logic       o_down;
    logic       o_sec_wr;
    logic [7:0] o_wr_data;
    logic [1:0] o_mode;

    modport slave (
        input  i_tick, i_btn_mode, i_btn_up, i_btn_down,
        input  i_sec_q, i_min_q, i_hr_q,
        output o_sec_ena, o_min_ena, o_hr_ena, o_up, o_down,
        output o_sec_wr, o_wr_data, o_mode
    );

    modport master (
        output i_tick, i_btn_mode, i_btn_up, i_btn_down,
        output i_sec_q, i_min_q, i_hr_q,
        input  o_sec_ena, o_min_ena, o_hr_ena, o_up, o_down,
        input  o_sec_wr, o_wr_data, o_mode
    );
endinterface

// File: rtl/clock_set_controller.sv
// Time-of-day set controller: forwards the 1 Hz tick with BCD carries in RUN,
// turns up/down presses into auto-repeating steps in the SET modes, and
// clears the seconds counter when setting ends.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | clock running; tick forwarded with carries, up/down ignored
// ST_SET_HR  | clock stopped; up/down steps go to the hours counter
// ST_SET_MIN | clock stopped; up/down steps go to the minutes counter
module clock_set_controller #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int TIMEOUT_TICKS = 30
) (
    input logic                    i_clk,
    input logic                    i_reset,
    clock_set_controller_if.slave  bus
);

    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               mode_prev_q, up_prev_q, down_prev_q;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic               lock_q, lock_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               sec_ena_q, sec_ena_d;
    logic               min_ena_q, min_ena_d;
    logic               hr_ena_q, hr_ena_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               sec_wr_q, sec_wr_d;
    logic               step;

    logic mode_rise, up_rise, down_rise, any_btn;

    assign mode_rise = bus.i_btn_mode & ~mode_prev_q;
    assign up_rise   = bus.i_btn_up   & ~up_prev_q;
    assign down_rise = bus.i_btn_down & ~down_prev_q;
    assign any_btn   = bus.i_btn_mode | bus.i_btn_up | bus.i_btn_down;

    // Next-state, step, repeat and timeout decisions for the coming cycle.
    always_comb begin
        state_d   = state_q;
        rpt_d     = rpt_q;
        lock_d    = lock_q;
        to_d      = to_q;
        sec_ena_d = 1'b0;
        min_ena_d = 1'b0;
        hr_ena_d  = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        sec_wr_d  = 1'b0;
        step      = 1'b0;

        // Conflicting up+down locks out stepping until both are released.
        if (bus.i_btn_up && bus.i_btn_down) begin
            lock_d = 1'b1;
        end else if (!bus.i_btn_up && !bus.i_btn_down) begin
            lock_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                rpt_d = '0;
                to_d  = '0;
                if (mode_rise) begin
                    state_d = ST_SET_HR;
                end else if (bus.i_tick) begin
                    sec_ena_d = 1'b1;
                    up_d      = 1'b1;
                    min_ena_d = (bus.i_sec_q == 8'h59);
                    hr_ena_d  = (bus.i_sec_q == 8'h59) && (bus.i_min_q == 8'h59);
                end
            end

            ST_SET_HR, ST_SET_MIN: begin
                if (any_btn) begin
                    to_d = '0;
                end else if (bus.i_tick) begin
                    to_d = to_q + TO_W'(1);
                end

                if (mode_rise) begin
                    // A held step button does not keep repeating into the next mode.
                    state_d  = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_RUN;
                    sec_wr_d = (state_q == ST_SET_MIN);
                    rpt_d    = '0;
                    to_d     = '0;
                end else if (!any_btn && bus.i_tick && (to_q == TO_W'(TIMEOUT_TICKS - 1))) begin
                    state_d  = ST_RUN;
                    sec_wr_d = 1'b1;
                    rpt_d    = '0;
                    to_d     = '0;
                end else begin
                    if (lock_q || !(bus.i_btn_up ^ bus.i_btn_down)) begin
                        rpt_d = '0;
                    end else if (up_rise || down_rise) begin
                        step  = 1'b1;
                        rpt_d = RPT_W'(HOLD_CYCLES);
                    end else if (rpt_q == RPT_W'(1)) begin
                        step  = 1'b1;
                        rpt_d = RPT_W'(REPEAT_CYCLES);
                    end else if (rpt_q != '0) begin
                        rpt_d = rpt_q - RPT_W'(1);
                    end

                    if (step) begin
                        up_d      = bus.i_btn_up;
                        down_d    = bus.i_btn_down;
                        hr_ena_d  = (state_q == ST_SET_HR);
                        min_ena_d = (state_q == ST_SET_MIN);
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                rpt_d   = '0;
                to_d    = '0;
            end
        endcase
    end

    // State, button history, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            rpt_q       <= '0;
            lock_q      <= 1'b0;
            to_q        <= '0;
            sec_ena_q   <= 1'b0;
            min_ena_q   <= 1'b0;
            hr_ena_q    <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            sec_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= bus.i_btn_mode;
            up_prev_q   <= bus.i_btn_up;
            down_prev_q <= bus.i_btn_down;
            rpt_q       <= rpt_d;
            lock_q      <= lock_d;
            to_q        <= to_d;
            sec_ena_q   <= sec_ena_d;
            min_ena_q   <= min_ena_d;
            hr_ena_q    <= hr_ena_d;
            up_q        <= up_d;
            down_q      <= down_d;
            sec_wr_q    <= sec_wr_d;
        end
    end

    assign bus.o_sec_ena = sec_ena_q;
    assign bus.o_min_ena = min_ena_q;
    assign bus.o_hr_ena  = hr_ena_q;
    assign bus.o_up      = up_q;
    assign bus.o_down    = down_q;
    assign bus.o_sec_wr  = sec_wr_q;
    assign bus.o_wr_data = 8'h00;
    assign bus.o_mode    = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: a vector table, hand-written auto-repeat
// and reset sequences, and random stimulus against a behavioural model.
module tb_clock_set_controller;

    localparam int HOLD = 10;
    localparam int REP  = 4;
    localparam int TMO  = 3;

    logic i_clk = 1'b0;
    logic i_reset;
    clock_set_controller_if bus();

    clock_set_controller #(
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_TICKS(TMO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         rst, tick, m, u, d;
        logic [7:0] sec, mn;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    // expected pack: {sec_ena, min_ena, hr_ena, up, down, sec_wr, mode[1:0]}
    function automatic logic [7:0] ex(bit se, bit me, bit he, bit eu, bit ed, bit wr, logic [1:0] md);
        return {se, me, he, eu, ed, wr, md};
    endfunction

    function automatic vec_t mk(bit rst, bit tick, bit m, bit u, bit d,
                                logic [7:0] sec, logic [7:0] mn, logic [7:0] e);
        vec_t v;
        v.rst = rst; v.tick = tick; v.m = m; v.u = u; v.d = d;
        v.sec = sec; v.mn = mn; v.e = e;
        return v;
    endfunction

    task automatic drive(bit rst, bit tick, bit m, bit u, bit d, logic [7:0] sec, logic [7:0] mn);
        i_reset        = rst;
        bus.i_tick     = tick;
        bus.i_btn_mode = m;
        bus.i_btn_up   = u;
        bus.i_btn_down = d;
        bus.i_sec_q    = sec;
        bus.i_min_q    = mn;
        bus.i_hr_q     = 8'h12;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(string name, int idx, logic [7:0] e);
        logic [15:0] got;
        got = {bus.o_wr_data, bus.o_sec_ena, bus.o_min_ena, bus.o_hr_ena,
               bus.o_up, bus.o_down, bus.o_sec_wr, bus.o_mode};
        total++;
        if (got !== {8'h00, e}) begin
            bad++;
            $display("FAIL %s #%0d got=%h exp=%h", name, idx, got, {8'h00, e});
        end
    endtask

    // Behavioural model: tracks how long the active button has been held
    // and derives steps arithmetically from that age.
    int m_mode, m_age, m_idle;
    bit m_conf, m_pm, m_pu, m_pd;

    task automatic model(bit rst, bit tick, bit bm, bit bu, bit bd,
                         logic [7:0] sec, logic [7:0] mn, output logic [7:0] e);
        bit mrise, urise, drise, any, rise, stp;
        bit se, me, he, eu, ed, wr;
        int nmode;
        se = 0; me = 0; he = 0; eu = 0; ed = 0; wr = 0; stp = 0;
        if (rst) begin
            m_mode = 0; m_age = -1; m_idle = 0; m_conf = 0;
            m_pm = 0; m_pu = 0; m_pd = 0;
            e = 8'h00;
            return;
        end
        mrise = bm && !m_pm;
        urise = bu && !m_pu;
        drise = bd && !m_pd;
        any   = bm || bu || bd;
        nmode = m_mode;
        if (m_mode == 0) begin
            m_age = -1; m_idle = 0;
            if (mrise) nmode = 1;
            else if (tick) begin
                se = 1; eu = 1;
                me = (sec == 8'h59);
                he = me && (mn == 8'h59);
            end
        end else begin
            if (any) m_idle = 0;
            else if (tick) m_idle++;
            if (mrise) begin
                nmode = (m_mode + 1) % 3;
                wr = (m_mode == 2);
                m_age = -1; m_idle = 0;
            end else if (m_idle == TMO) begin
                nmode = 0; wr = 1; m_age = -1; m_idle = 0;
            end else if (m_conf || !(bu ^ bd)) begin
                m_age = -1;
            end else begin
                rise = bu ? urise : drise;
                if (rise) begin
                    m_age = 0; stp = 1;
                end else if (m_age >= 0) begin
                    m_age++;
                    stp = (m_age >= HOLD) && ((m_age - HOLD) % REP == 0);
                end
                if (stp) begin
                    eu = bu; ed = bd;
                    he = (m_mode == 1);
                    me = (m_mode == 2);
                end
            end
        end
        if (bu && bd) m_conf = 1;
        else if (!bu && !bd) m_conf = 0;
        m_pm = bm; m_pu = bu; m_pd = bd;
        m_mode = nmode;
        e = {se, me, he, eu, ed, wr, 2'(nmode)};
    endtask

    initial begin
        logic [7:0] e;
        bit rb, tb_, mb, ub, db;
        logic [7:0] sec, mn;
        logic [3:0] t, o;

        // rst tick m u d sec min -> {se me he up dn wr mode}
        vecs.push_back(mk(1,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h37,8'h12, ex(1,0,0,1,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,8'h38,8'h12, ex(0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h59,8'h12, ex(1,1,0,1,0,0,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h59,8'h59, ex(1,1,1,1,0,0,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h58,8'h59, ex(1,0,0,1,0,0,0)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,0,1,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,1,1,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,0,1,1,0,0,1)));
        vecs.push_back(mk(0,1,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,0,1,8'h00,8'h00, ex(0,0,1,0,1,0,1)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,1,1,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,1,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,1,0,1,0,0,2)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(0,0,1,0,0,8'h00,8'h00, ex(0,0,0,0,0,1,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h10,8'h00, ex(1,0,0,1,0,0,0)));
        vecs.push_back(mk(0,0,1,0,0,8'h10,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,0,0,8'h10,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,1,0,0,0,8'h10,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,1,0,0,0,8'h10,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,1,0,0,0,8'h10,8'h00, ex(0,0,0,0,0,1,0)));
        vecs.push_back(mk(0,1,0,0,0,8'h10,8'h00, ex(1,0,0,1,0,0,0)));
        vecs.push_back(mk(0,0,1,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,0,1,1,0,0,1)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,1)));
        vecs.push_back(mk(0,0,1,1,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(0,0,0,1,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,2)));
        vecs.push_back(mk(1,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,8'h00,8'h00, ex(0,0,0,0,0,0,0)));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].tick, vecs[i].m, vecs[i].u, vecs[i].d,
                  vecs[i].sec, vecs[i].mn);
            check("vec", i, vecs[i].e);
        end

        // Auto-repeat: hold down 30 cycles in SET_MIN.
        drive(1,0,0,0,0,8'h00,8'h00);
        drive(0,0,1,0,0,8'h00,8'h00);
        drive(0,0,0,0,0,8'h00,8'h00);
        drive(0,0,1,0,0,8'h00,8'h00);
        drive(0,0,0,0,0,8'h00,8'h00);
        check("enter_set_min", 0, ex(0,0,0,0,0,0,2));
        for (int k = 0; k < 30; k++) begin
            bit s;
            s = (k == 0) || (k == 10) || (k == 14) || (k == 18) || (k == 22) || (k == 26);
            drive(0,0,0,0,1,8'h00,8'h00);
            check("repeat", k + 1, ex(0,s,0,0,s,0,2));
        end
        drive(0,0,0,0,0,8'h00,8'h00);
        check("repeat_release", 0, ex(0,0,0,0,0,0,2));

        // Reset asserted mid-hold in SET_MIN: no strobe, no seconds write.
        for (int k = 0; k < 12; k++) drive(0,0,0,1,0,8'h00,8'h00);
        drive(1,0,0,1,0,8'h00,8'h00);
        check("reset_mid_hold", 0, ex(0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            drive(0,1,0,1,0,8'h05,8'h00);
            check("after_reset_run", k, ex(1,0,0,1,0,0,0));
        end
        drive(0,0,0,0,0,8'h00,8'h00);
        check("after_reset_idle", 0, ex(0,0,0,0,0,0,0));

        // Random stimulus against the model.
        model(1,0,0,0,0,8'h00,8'h00,e);
        drive(1,0,0,0,0,8'h00,8'h00);
        check("rand_reset", 0, e);
        mb = 0; ub = 0; db = 0;
        for (int c = 0; c < 4000; c++) begin
            rb  = ($urandom_range(0, 499) == 0);
            tb_ = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) mb = ~mb;
            if ($urandom_range(0, 11) == 0) ub = ~ub;
            if ($urandom_range(0, 11) == 0) db = ~db;
            t = 4'($urandom_range(0, 5));
            o = 4'($urandom_range(0, 9));
            sec = ($urandom_range(0, 2) == 0) ? 8'h59 : {t, o};
            t = 4'($urandom_range(0, 5));
            o = 4'($urandom_range(0, 9));
            mn  = ($urandom_range(0, 1) == 0) ? 8'h59 : {t, o};
            model(rb, tb_, mb, ub, db, sec, mn, e);
            drive(rb, tb_, mb, ub, db, sec, mn);
            check("rand", c, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequences the three time-of-day counters of the Mimas V2 clock (seconds and minutes `count_to_60_updown`, hours 0-23 up/down counter). In RUN mode it forwards the 1 Hz tick and cascades carries from seconds to minutes to hours. In SET modes it turns debounced push-button presses into single-cycle up/down steps with auto-repeat, and issues a seconds clear when setting ends. It sits between the button debouncers/tick generator and the counter bank, and drives the display-blink mode lines.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a button must be held before auto-repeat starts (1 s at 50 MHz)
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat steps (5 Hz)
- TIMEOUT_TICKS, 30: i_tick pulses with no button activity before a SET mode returns to RUN
- i_clk  in  1  system clock; one clock domain
- i_reset  in  1  reset, synchronous, active-high
- i_tick  in  1  1 Hz timebase, single-cycle pulse
- i_btn_mode, i_btn_up, i_btn_down  in  1 each  debounced buttons, level, active-high
- i_sec_q, i_min_q  in  8  BCD counter values, 00-59
- i_hr_q  in  8  BCD hour value, 00-23
- o_sec_ena, o_min_ena, o_hr_ena  out  1 each  single-cycle step strobe per counter
- o_up, o_down  out  1 each  direction lines shared by all counters; valid whenever any ena is high
- o_sec_wr  out  1  single-cycle load strobe for the seconds counter
- o_wr_data  out  8  load value; always 8'h00
- o_mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 unused)

## Operation
- All inputs are sampled on the rising edge of i_clk. Button edges are detected against a registered copy of the previous value.
- FSM states:
  - RUN: a mode rising edge goes to SET_HR.
  - SET_HR: a mode rising edge goes to SET_MIN.
  - SET_MIN: a mode rising edge goes to RUN.
  - Timeout: either SET state goes to RUN once TIMEOUT_TICKS i_tick pulses have occurred with no up, down or mode activity. The activity counter clears on any button edge and while any button is held.
- RUN behaviour:
  - Each i_tick produces o_sec_ena with o_up=1, o_down=0.
  - o_min_ena is also asserted when i_sec_q==8'h59.
  - o_hr_ena is also asserted when i_sec_q==8'h59 and i_min_q==8'h59.
  - Up and down buttons are ignored.
- SET behaviour:
  - i_tick is not forwarded, so the clock stops.
  - A step goes to the selected counter only: o_hr_ena in SET_HR, o_min_ena in SET_MIN.
  - Step with o_up=1/o_down=0 on an up press; o_up=0/o_down=1 on a down press.
- Auto-repeat:
  - A rising edge gives one step.
  - If the button is still held HOLD_CYCLES after that edge, a step is issued, then one more every REPEAT_CYCLES while it stays held.
  - Releasing the button clears the repeat counter.
- Up and down high in the same cycle, or one pressed while the other is held: no steps, and the repeat counter stays cleared until both are released.
- Leaving SET_MIN (by button or timeout) issues one o_sec_wr pulse with o_wr_data=8'h00. Leaving SET_HR by timeout issues the same pulse.
- Wrap-around (59→00, 23→00, 00→59) belongs to the counters; the controller never clamps.

## Timing
- Reset: state RUN, o_mode=00, all ena=0, o_up=0, o_down=0, o_sec_wr=0, o_wr_data=8'h00, and all repeat/timeout counters 0.
- All outputs are registered. Latency is exactly 1 cycle: an event sampled at edge N drives its outputs during cycle N+1.
- Carry decisions use i_sec_q/i_min_q as sampled at the same edge as i_tick, i.e. the value before the increment.
- Ena strobes are exactly 1 cycle wide. o_up/o_down are driven in the same cycle as the strobe and return to 0 the cycle after.
- The mode change and the o_sec_wr pulse appear in the same cycle. No step strobe is issued in that cycle.
- A step and a mode edge sampled in the same cycle: the mode change wins and the step is dropped.
- i_tick coincident with entry to RUN: the tick is forwarded, so o_sec_ena is asserted the cycle after o_sec_wr.
- Reset asserted mid-repeat or mid-SET: the next cycle shows reset values, and no o_sec_wr pulse is issued.

## Test plan
- Reset, then RUN with i_sec_q=8'h37 and a tick → o_sec_ena=1, o_up=1 for one cycle; o_min_ena=0.
- i_sec_q=8'h59, i_min_q=8'h59, tick → o_sec_ena, o_min_ena and o_hr_ena all 1 in the same cycle.
- Press mode once → o_mode=01; up press → one o_hr_ena with o_up=1; ticks produce no o_sec_ena.
- With HOLD_CYCLES=10 and REPEAT_CYCLES=4, hold down for 30 cycles in SET_MIN → o_min_ena with o_down=1 at +1, +11, +15, +19, +23, +27 cycles.
- Hold up and down together in SET_HR → no ena. Mode pressed twice → o_mode goes 10 then 00, with a single o_sec_wr=1 and o_wr_data=8'h00.
- In SET_HR, with TIMEOUT_TICKS=3 and no buttons, send 3 ticks → o_mode=00 and o_sec_wr pulses once. Reset asserted mid-hold → all outputs 0 and no strobe.
